breakout_lvds_tx: RTL and testbench

Serializes 12-bit breakout-to-host words onto the LVDS return link. It drives the LVDS_OUT[0] bit clock, LVDS_OUT[1] data and LVDS_OUT[2] word-frame marker. It periodically inserts a sync word so the host can align, and fills gaps with idle words. It sits between the breakout status/digital-input packer and the LVDS output buffers.

---
 rtl/breakout_lvds_tx.sv | 76 +++++++
 tb/tb_breakout_lvds_tx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/breakout_lvds_tx.sv
// breakout_lvds_tx: serializes 12-bit words onto LVDS bit clock/data/frame lines with periodic sync and idle fill.
// Define BREAKOUT_TX_PARITY_EN to append an odd-parity bit after each word's LSB.
module breakout_lvds_tx #(
  parameter int          CLK_DIV       = 4,
  parameter logic [11:0] SYNC_WORD     = 12'b000100000000,
  parameter logic [11:0] IDLE_WORD     = 12'h000,
  parameter int          SYNC_INTERVAL = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        tx_clk,
  output logic        tx_data,
  output logic        tx_frame
);
`ifdef BREAKOUT_TX_PARITY_EN
  localparam int WL = 13;
`else
  localparam int WL = 12;
`endif
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int CW = $clog2(SYNC_INTERVAL + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);
  logic [PW-1:0] ph, ph_nxt;
  logic [3:0] bit_idx, bit_dec;
  logic [CW-1:0] sync_cnt;
  logic sync_due, wrap, bnd;
  logic [11:0] sel;
  logic [WL-1:0] wbuf, load;
  assign wrap = ph == PH_LAST;
  assign bnd = bit_idx == 4'd0;
  assign ph_nxt = wrap ? '0 : ph + 1'b1;
  assign bit_dec = bit_idx - 4'd1;
  assign data_ready = wrap && bnd && !sync_due;
  assign sel = sync_due ? SYNC_WORD : data_valid ? data_in : IDLE_WORD;
`ifdef BREAKOUT_TX_PARITY_EN
  assign load = {sel, ~^sel};
`else
  assign load = sel;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph <= '0;
      bit_idx <= 4'd0;
      sync_cnt <= '0;
      sync_due <= 1'b1;
      wbuf <= '0;
      tx_clk <= 1'b0;
      tx_data <= 1'b0;
      tx_frame <= 1'b0;
    end else begin
      ph <= ph_nxt;
      tx_clk <= ph_nxt >= PW'(CLK_DIV);
      if (wrap) begin
        tx_frame <= bnd;
        if (bnd) begin
          wbuf <= load;
          tx_data <= load[WL-1];
          bit_idx <= 4'(WL - 1);
          if (sync_due) begin
            sync_cnt <= '0;
            sync_due <= 1'b0;
          end else if (data_valid) begin
            sync_cnt <= sync_cnt + 1'b1;
            sync_due <= sync_cnt == CW'(SYNC_INTERVAL - 1);
          end
        end else begin
          tx_data <= wbuf[bit_dec];
          bit_idx <= bit_dec;
        end
      end
    end
  end
endmodule

// File: tb/tb_breakout_lvds_tx.sv
// tb_breakout_lvds_tx: directed checks of framing, sync insertion, idle fill and reset recovery.
module tb_breakout_lvds_tx;
`ifdef BREAKOUT_TX_PARITY_EN
  localparam int WL = 13;
`else
  localparam int WL = 12;
`endif
  localparam int BP = 8 * WL;
  logic clk = 1'b0, reset_n = 1'b0, data_valid = 1'b0;
  logic [11:0] data_in = '0;
  logic data_ready, tx_clk, tx_data, tx_frame;
  int cyc = -1, n_chk = 0, n_pass = 0, st = 0, nb = 0, fidx = 0, rel = 0;
  logic [12:0] cur = '0;
  logic in_word = 1'b0, prev_frame = 1'b0, feed_en = 1'b0, xfer = 1'b0;
  logic [11:0] words[$];
  logic pars[$];
  int starts[$], rdy[$];
  breakout_lvds_tx dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .tx_clk(tx_clk), .tx_data(tx_data), .tx_frame(tx_frame)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    xfer = feed_en && reset_n && data_ready && data_valid;
    if (!reset_n) begin
      in_word = 1'b0;
      prev_frame = 1'b0;
    end else begin
      if (data_ready) rdy.push_back(cyc);
      if (tx_frame && !prev_frame) begin
        cur = '0;
        nb = 0;
        st = cyc;
        in_word = 1'b1;
      end
      if (in_word && ((cyc - st) % 8) == 4) begin
        cur = {cur[11:0], tx_data};
        nb++;
        if (nb == WL) begin
          words.push_back(WL == 13 ? cur[12:1] : cur[11:0]);
          pars.push_back(cur[0]);
          starts.push_back(st);
          in_word = 1'b0;
        end
      end
      prev_frame = tx_frame;
    end
  end
  always @(posedge clk) if (xfer) begin
    #1;
    if (fidx < 9) begin
      fidx++;
      data_in = 12'(fidx + 1);
    end else data_valid = 1'b0;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic do_reset(input logic dv, input logic [11:0] d, input logic fe);
    reset_n = 1'b0;
    data_valid = dv;
    data_in = d;
    feed_en = fe;
    fidx = 0;
    words.delete();
    pars.delete();
    starts.delete();
    rdy.delete();
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    cyc = -1;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int hits;
    logic [11:0] exp_c[12];
    do_reset(1'b0, 12'h000, 1'b0);
    wait_cyc(0);
    chk("reset_outs", {tx_clk, tx_data, tx_frame, data_ready}, 4'b0000);
    wait_cyc(7);
    chk("frame_c7", tx_frame, 1'b0);
    wait_cyc(8);
    chk("frame_c8", tx_frame, 1'b1);
    wait_cyc(11);
    chk("txclk_c11", tx_clk, 1'b0);
    wait_cyc(12);
    chk("txclk_c12", tx_clk, 1'b1);
    wait_cyc(15);
    chk("frame_c15", tx_frame, 1'b1);
    wait_cyc(16);
    chk("frame_c16", tx_frame, 1'b0);
    wait_cyc(BP + 6);
    chk("no_early_ready", rdy.size(), 0);
    wait_cyc(2 * BP + 8 + 8 * WL + 8);
    chk("sync_word", words[0], 12'h100);
    chk("sync_start", starts[0], 8);
    chk("idle_word", words[1], 12'h000);
    chk("idle_start", starts[1], BP + 8);
    chk("first_slot", rdy[0], BP + 7);
    do_reset(1'b1, 12'h7F0, 1'b0);
    wait_cyc(BP + 11);
    chk("txclk_mid_lo", tx_clk, 1'b0);
    wait_cyc(BP + 12);
    chk("txclk_mid_hi", tx_clk, 1'b1);
    wait_cyc(2 * BP + 20);
    chk("data_slot", rdy[0], BP + 7);
    chk("data_word", words[1], 12'h7F0);
    chk("data_start", starts[1], BP + 8);
    do_reset(1'b1, 12'h001, 1'b1);
    wait_cyc(12 * BP + 48);
    exp_c = '{12'h100, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006, 12'h007, 12'h008, 12'h100, 12'h009, 12'h00A};
    for (int i = 0; i < 12; i++) chk($sformatf("seq_w%0d", i), words[i], exp_c[i]);
    hits = 0;
    foreach (rdy[i]) if (rdy[i] == 9 * BP + 7) hits++;
    chk("no_slot_pre_sync", hits, 0);
    chk("slot_w8", rdy[7], 8 * BP + 7);
    chk("slot_w10", rdy[8], 10 * BP + 7);
    chk("slot_w11", rdy[9], 11 * BP + 7);
    feed_en = 1'b0;
    do_reset(1'b1, 12'h7F0, 1'b0);
    wait_cyc(BP + 50);
    data_valid = 1'b0;
    wait_cyc(2 * BP + 50);
    data_valid = 1'b1;
    data_in = 12'hA0F;
    wait_cyc(11 * BP + 48);
    chk("gap_slot", rdy[1], 2 * BP + 7);
    chk("gap_idle", words[2], 12'h000);
    chk("gap_idle_start", starts[2], 2 * BP + 8);
    chk("gap_next", words[3], 12'hA0F);
    chk("gap_next_start", starts[3], 3 * BP + 8);
    chk("gap_last_data", words[9], 12'hA0F);
    chk("gap_sync_after", words[10], 12'h100);
    do_reset(1'b1, 12'h7F0, 1'b0);
    wait_cyc(150);
    reset_n = 1'b0;
    words.delete();
    pars.delete();
    starts.delete();
    rdy.delete();
    #1;
    chk("midrst_now", {tx_clk, tx_data, tx_frame, data_ready}, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("midrst_c%0d", i), {tx_clk, tx_data, tx_frame, data_ready}, 4'b0000);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    rel = cyc + 1;
    wait_cyc(rel + BP + 20);
    chk("midrst_sync", words[0], 12'h100);
    chk("midrst_start", starts[0], rel + 8);
`ifdef BREAKOUT_TX_PARITY_EN
    do_reset(1'b1, 12'hFFF, 1'b0);
    wait_cyc(2 * BP + 20);
    chk("par_word", words[1], 12'hFFF);
    chk("par_ones", pars[1], 1'b1);
    chk("par_sync", pars[0], 1'b0);
    chk("par_period", starts[1] - starts[0], 104);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
